// File: rtl/mult_hilo_if.sv
// Pipeline-side bundle for the multiply sequencer: issue, HI/LO move requests and the ALU multiply path.
interface mult_hilo_if;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        mf_req;
  logic        mf_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output start, signed_op, a, b, mthi, mtlo, wdata, mf_req, mf_sel, alu_hi, alu_lo,
    input  alu_a, alu_b, alu_op, rdata, rdata_valid, busy, stall, done
  );

  modport slave (
    input  start, signed_op, a, b, mthi, mtlo, wdata, mf_req, mf_sel, alu_hi, alu_lo,
    output alu_a, alu_b, alu_op, rdata, rdata_valid, busy, stall, done
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Multi-cycle multiply sequencer owning the HI/LO pair; the ALU operands are held stable
// for MULT_LAT cycles and the full 64-bit product is committed into HI/LO.
module mult_hilo_ctrl #(
  parameter int unsigned MULT_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_hilo_if.slave  bus
);

  localparam logic [3:0] LAT_M1     = 4'(MULT_LAT - 1);
  localparam logic [3:0] OP_MULT    = 4'b0110;
  localparam logic [3:0] OP_MULTU   = 4'b0111;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        accept_s;
  logic        commit_s;
  logic        idle_s;
  logic [31:0] hi_r, lo_r;
  logic [31:0] alu_a_r, alu_b_r;
  logic [3:0]  alu_op_r;
  logic        done_r;

  // State and latency counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, commit when the counter is exhausted
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          cnt_s    = LAT_M1;
          state_s  = BUSY;
        end else begin
          cnt_s    = cnt_r;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          commit_s = 1'b1;
          state_s  = IDLE;
        end else begin
          cnt_s    = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  assign idle_s = (state_r == IDLE);

  // ALU operand latch, HI/LO writes (commit has priority over an mt* only in principle:
  // mt* is accepted only in IDLE, commit only happens in BUSY) and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r  <= 32'd0;
      alu_b_r  <= 32'd0;
      alu_op_r <= OP_MULTU;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      done_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_a_r  <= bus.a;
        alu_b_r  <= bus.b;
        alu_op_r <= bus.signed_op ? OP_MULT : OP_MULTU;
      end
      if (commit_s) begin
        hi_r <= bus.alu_hi;
        lo_r <= bus.alu_lo;
      end else begin
        if (idle_s && bus.mthi) hi_r <= bus.wdata;
        if (idle_s && bus.mtlo) lo_r <= bus.wdata;
      end
      done_r <= commit_s;
    end
  end

  assign bus.alu_a       = alu_a_r;
  assign bus.alu_b       = alu_b_r;
  assign bus.alu_op      = alu_op_r;
  assign bus.busy        = ~idle_s;
  assign bus.done        = done_r;
  assign bus.rdata       = bus.mf_sel ? hi_r : lo_r;
  assign bus.rdata_valid = bus.mf_req & idle_s;
  assign bus.stall       = ~idle_s & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl: a MULT_LAT=4 instance and a MULT_LAT=1 instance,
// each driven against a behavioural ALU, with expected products queued at issue time.
module tb_mult_hilo_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [63:0] q4[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  mult_hilo_if b4 ();
  mult_hilo_if b1 ();

  mult_hilo_ctrl #(.MULT_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  mult_hilo_ctrl #(.MULT_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  function automatic logic [63:0] alu_model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
    logic signed [63:0] sp;
    if (op == 4'b0110) begin
      sp = $signed(x) * $signed(y);
      return sp;
    end else if (op == 4'b0111) begin
      return {32'd0, x} * {32'd0, y};
    end else begin
      return 64'd0;
    end
  endfunction

  assign {b4.alu_hi, b4.alu_lo} = alu_model(b4.alu_a, b4.alu_b, b4.alu_op);
  assign {b1.alu_hi, b1.alu_lo} = alu_model(b1.alu_a, b1.alu_b, b1.alu_op);

  function automatic logic [63:0] expect_prod(input logic [31:0] x, input logic [31:0] y, input bit s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b4.start = 1'b0; b4.signed_op = 1'b0; b4.a = 32'd0; b4.b = 32'd0;
    b4.mthi = 1'b0; b4.mtlo = 1'b0; b4.wdata = 32'd0; b4.mf_req = 1'b0; b4.mf_sel = 1'b0;
    b1.start = 1'b0; b1.signed_op = 1'b0; b1.a = 32'd0; b1.b = 32'd0;
    b1.mthi = 1'b0; b1.mtlo = 1'b0; b1.wdata = 32'd0; b1.mf_req = 1'b0; b1.mf_sel = 1'b0;
  endtask

  // rdata is a pure mux, so HI and LO can both be observed within one cycle
  task automatic read4(output logic [31:0] hi, output logic [31:0] lo);
    logic sel_save;
    sel_save = b4.mf_sel;
    b4.mf_sel = 1'b1; #1 hi = b4.rdata;
    b4.mf_sel = 1'b0; #1 lo = b4.rdata;
    b4.mf_sel = sel_save;
  endtask

  task automatic read1(output logic [31:0] hi, output logic [31:0] lo);
    b1.mf_sel = 1'b1; #1 hi = b1.rdata;
    b1.mf_sel = 1'b0; #1 lo = b1.rdata;
  endtask

  // Issue one multiply on the MULT_LAT=4 instance, optionally holding an mfhi request throughout
  task automatic mult4(input logic [31:0] x, input logic [31:0] y, input bit s, input bit hold_mf,
                       output logic [31:0] hi, output logic [31:0] lo);
    int cyc;
    logic [63:0] exp_p;
    q4.push_back(expect_prod(x, y, s));
    b4.a = x; b4.b = y; b4.signed_op = s; b4.start = 1'b1;
    b4.mf_req = hold_mf; b4.mf_sel = 1'b1;
    tick();
    b4.start = 1'b0;
    cyc = 0;
    while (b4.busy === 1'b1 && cyc < 20) begin
      if (hold_mf) begin
        n_checks++;
        if (b4.stall !== 1'b1 || b4.rdata_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL mf_during_busy: stall=%b rdata_valid=%b, want 1/0", b4.stall, b4.rdata_valid);
        end
      end
      if (cyc == 0) begin
        n_checks++;
        if (b4.alu_op !== (s ? 4'b0110 : 4'b0111)) begin
          n_errors++;
          $display("FAIL alu_op: got %h want %h", b4.alu_op, s ? 4'b0110 : 4'b0111);
        end
      end
      cyc++;
      tick();
    end
    n_checks++;
    if (cyc !== 4) begin n_errors++; $display("FAIL busy_len: got %0d want 4", cyc); end
    n_checks++;
    if (b4.done !== 1'b1) begin n_errors++; $display("FAIL done_pulse: got %b want 1", b4.done); end
    if (hold_mf) begin
      n_checks++;
      if (b4.rdata_valid !== 1'b1) begin
        n_errors++; $display("FAIL mf_after_done: rdata_valid=%b want 1", b4.rdata_valid);
      end
    end
    read4(hi, lo);
    exp_p = (q4.size() > 0) ? q4.pop_front() : 64'hx;
    n_checks++;
    if ({hi, lo} !== exp_p) begin
      n_errors++; $display("FAIL product: got %h_%h want %h", hi, lo, exp_p);
    end
    b4.mf_req = 1'b0;
    tick();
    n_checks++;
    if (b4.done !== 1'b0) begin n_errors++; $display("FAIL done_width: got %b want 0", b4.done); end
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    read4(hi, lo);
    n_checks++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.stall !== 1'b0) begin
      n_errors++; $display("FAIL reset_ctrl: busy=%b done=%b stall=%b want 0", b4.busy, b4.done, b4.stall);
    end
    n_checks++;
    if (b4.alu_a !== 32'd0 || b4.alu_b !== 32'd0 || b4.alu_op !== 4'b0111) begin
      n_errors++; $display("FAIL reset_alu: a=%h b=%h op=%h want 0/0/7", b4.alu_a, b4.alu_b, b4.alu_op);
    end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_errors++; $display("FAIL reset_hilo: got %h_%h want 0", hi, lo);
    end
  endtask

  task automatic test_signed();
    logic [31:0] hi, lo;
    mult4(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, hi, lo);
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      n_errors++; $display("FAIL signed_example: got %h_%h want FFFFFFFF_FFFFFFF1", hi, lo);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] hi, lo;
    mult4(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, hi, lo);
    n_checks++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      n_errors++; $display("FAIL unsigned_example: got %h_%h want 00000001_FFFFFFFE", hi, lo);
    end
  endtask

  task automatic test_mt();
    logic [31:0] hi, lo;
    int cyc;
    // HI holds 1 from the unsigned test; an mthi raised during BUSY must not touch it
    b4.a = 32'd3; b4.b = 32'd4; b4.signed_op = 1'b0; b4.start = 1'b1;
    tick();
    b4.start = 1'b0; b4.mthi = 1'b1; b4.wdata = 32'h0000_1234; b4.mf_sel = 1'b1;
    cyc = 0;
    while (b4.busy === 1'b1 && cyc < 20) begin
      #1;
      n_checks++;
      if (b4.stall !== 1'b1 || b4.rdata !== 32'h0000_0001) begin
        n_errors++; $display("FAIL mthi_busy: stall=%b hi=%h want 1/00000001", b4.stall, b4.rdata);
      end
      cyc++;
      tick();
    end
    n_checks++;
    if (b4.stall !== 1'b0) begin n_errors++; $display("FAIL mthi_release: stall=%b want 0", b4.stall); end
    tick();
    b4.mthi = 1'b0;
    read4(hi, lo);
    n_checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'd12) begin
      n_errors++; $display("FAIL mthi_after_commit: got %h_%h want 00001234_0000000C", hi, lo);
    end
    // Both moves together, with an mflo in the same cycle seeing the pre-write value
    b4.mthi = 1'b1; b4.mtlo = 1'b1; b4.wdata = 32'hA5A5_0F0F; b4.mf_req = 1'b1; b4.mf_sel = 1'b0;
    #1;
    n_checks++;
    if (b4.rdata_valid !== 1'b1 || b4.rdata !== 32'd12) begin
      n_errors++; $display("FAIL mf_prewrite: valid=%b rdata=%h want 1/0000000C", b4.rdata_valid, b4.rdata);
    end
    tick();
    b4.mthi = 1'b0; b4.mtlo = 1'b0; b4.mf_req = 1'b0;
    read4(hi, lo);
    n_checks++;
    if (hi !== 32'hA5A5_0F0F || lo !== 32'hA5A5_0F0F) begin
      n_errors++; $display("FAIL mthi_mtlo: got %h_%h want A5A50F0F_A5A50F0F", hi, lo);
    end
  endtask

  task automatic test_start_with_mt();
    logic [31:0] hi, lo;
    b4.a = 32'd7; b4.b = 32'd6; b4.signed_op = 1'b0; b4.start = 1'b1;
    b4.mthi = 1'b1; b4.mtlo = 1'b1; b4.wdata = 32'h0000_CAFE;
    tick();
    b4.start = 1'b0; b4.mthi = 1'b0; b4.mtlo = 1'b0;
    read4(hi, lo);
    n_checks++;
    if (hi !== 32'h0000_CAFE || lo !== 32'h0000_CAFE || b4.busy !== 1'b1) begin
      n_errors++; $display("FAIL start_mt_t0: got %h_%h busy=%b want CAFE/CAFE/1", hi, lo, b4.busy);
    end
    for (int i = 0; i < 20 && b4.busy === 1'b1; i++) tick();
    read4(hi, lo);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      n_errors++; $display("FAIL start_mt_commit: got %h_%h want 0_0000002A", hi, lo);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [31:0] hi, lo;
    int seen_done;
    b4.a = 32'd9; b4.b = 32'd9; b4.signed_op = 1'b1; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (b4.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", b4.busy); end
    tick(); tick();
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b4.done === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin n_errors++; $display("FAIL abort_done: got %0d pulses want 0", seen_done); end
    read4(hi, lo);
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || b4.alu_op !== 4'b0111) begin
      n_errors++; $display("FAIL abort_hilo: got %h_%h op=%h want 0_0/7", hi, lo, b4.alu_op);
    end
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, x, y;
    for (int i = 0; i < 4; i++) begin
      x = $urandom();
      y = $urandom();
      mult4(x, y, i[0], 1'b0, hi, lo);
    end
  endtask

  // MULT_LAT=1 with start held: accept, commit, accept, commit ...
  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    logic [63:0] exp_p;
    b1.a = 32'h8000_0000; b1.b = 32'd2; b1.signed_op = 1'b1; b1.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (b1.busy === 1'b0) q1.push_back(expect_prod(b1.a, b1.b, 1'b1));
      tick();
      n_checks++;
      if (b1.busy !== ((i % 2) == 0) || b1.done !== ((i % 2) == 1)) begin
        n_errors++; $display("FAIL b2b_cycle%0d: busy=%b done=%b want %b/%b", i, b1.busy, b1.done,
                             (i % 2) == 0, (i % 2) == 1);
      end
      if (b1.done === 1'b1) begin
        read1(hi, lo);
        exp_p = (q1.size() > 0) ? q1.pop_front() : 64'hx;
        n_checks++;
        if ({hi, lo} !== exp_p || exp_p !== 64'hFFFF_FFFF_0000_0000) begin
          n_errors++; $display("FAIL b2b_product: got %h_%h want FFFFFFFF_00000000", hi, lo);
        end
      end
    end
    b1.start = 1'b0;
    tick();
    n_checks++;
    if (q1.size() != 0 || b1.busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_drain: queue=%0d busy=%b want 0/0", q1.size(), b1.busy);
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_mt();
    test_start_with_mt();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
